// File: rtl/alu_pkg.sv
// Shared opcode map and flag layout for the pipelined ALU (alu_pipe).
package alu_pkg;

  localparam int unsigned NB_OPERATION = 6;
  localparam int unsigned NB_FLAGS     = 4;

  localparam logic [NB_OPERATION-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OPERATION-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OPERATION-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OPERATION-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OPERATION-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OPERATION-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OPERATION-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OPERATION-1:0] OP_SRL = 6'b000010;

  // o_flags = {zero, negative, carry, overflow}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic is_legal_op(input logic [NB_OPERATION-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its own content
// is leaving in the same cycle, so a chain of slices runs at full throughput.
module alu_pipe_stage #(
  parameter int unsigned NB_PAYLOAD = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready_c,
  input  logic [NB_PAYLOAD-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NB_PAYLOAD-1:0] o_data
);

  logic                  r_valid;
  logic [NB_PAYLOAD-1:0] r_data;

  assign o_ready_c = !r_valid || i_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready flow control and illegal-opcode detection.
// Define ALU_FLAGS_EN to build the {zero, negative, carry, overflow} flags.
module alu_pipe #(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_OPERATION = 6,
  parameter int unsigned N_STAGES     = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  input  logic [NB_OPERATION-1:0] i_operation,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NB_DATA-1:0]      o_result,
  output logic                    o_illegal,
  output logic [3:0]              o_flags
);
  import alu_pkg::*;

  if (NB_OPERATION != alu_pkg::NB_OPERATION) begin : g_bad_nb_operation
    $error("alu_pipe: NB_OPERATION must be 6");
  end
  if (N_STAGES < 1 || N_STAGES > 4) begin : g_bad_n_stages
    $error("alu_pipe: N_STAGES must be in 1..4");
  end
  if (NB_DATA < 2) begin : g_bad_nb_data
    $error("alu_pipe: NB_DATA must be >= 2");
  end

  localparam int unsigned NB_SH  = $clog2(NB_DATA);
  localparam int unsigned MSB    = NB_DATA - 1;
`ifdef ALU_FLAGS_EN
  localparam int unsigned NB_PAYLOAD = NB_DATA + 1 + NB_FLAGS;
`else
  localparam int unsigned NB_PAYLOAD = NB_DATA + 1;
`endif

  logic [NB_SH-1:0]      w_sh;
  logic [NB_DATA-1:0]    w_result;
  logic                  w_illegal;
  logic [NB_PAYLOAD-1:0] w_payload;

  assign w_sh = i_data_b[NB_SH-1:0];

  // Combinational ALU feeding stage 1
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (i_operation)
      OP_ADD:  w_result = i_data_a + i_data_b;
      OP_SUB:  w_result = i_data_a - i_data_b;
      OP_AND:  w_result = i_data_a & i_data_b;
      OP_OR:   w_result = i_data_a | i_data_b;
      OP_XOR:  w_result = i_data_a ^ i_data_b;
      OP_NOR:  w_result = ~(i_data_a | i_data_b);
      OP_SRA:  w_result = NB_DATA'($signed(i_data_a) >>> w_sh);
      OP_SRL:  w_result = i_data_a >> w_sh;
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [NB_FLAGS-1:0] w_flags;

  // Carry/borrow from unsigned compares against the wrapped result, so no
  // widened adder is needed beside the main one.
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_Z] = (w_result == '0);
    w_flags[FLAG_N] = w_result[MSB];
    case (i_operation)
      OP_ADD: begin
        w_flags[FLAG_C] = (w_result < i_data_a);
        w_flags[FLAG_V] = (i_data_a[MSB] == i_data_b[MSB]) && (w_result[MSB] != i_data_a[MSB]);
      end
      OP_SUB: begin
        w_flags[FLAG_C] = (i_data_a >= i_data_b);
        w_flags[FLAG_V] = (i_data_a[MSB] != i_data_b[MSB]) && (w_result[MSB] != i_data_a[MSB]);
      end
      default: ;
    endcase
  end

  assign w_payload = {w_flags, w_illegal, w_result};
`else
  assign w_payload = {w_illegal, w_result};
`endif

  // Stage chain: index g is the input side of slice g, index N_STAGES the output
  logic [N_STAGES:0]                 w_valid;
  logic [N_STAGES:0]                 w_ready;
  logic [N_STAGES:0][NB_PAYLOAD-1:0] w_data;

  assign w_valid[0]        = i_valid;
  assign w_data[0]         = w_payload;
  assign w_ready[N_STAGES] = i_ready;
  assign o_ready           = w_ready[0];

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    alu_pipe_stage #(
      .NB_PAYLOAD (NB_PAYLOAD)
    ) u_stage (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_valid   (w_valid[g]),
      .o_ready_c (w_ready[g]),
      .i_data    (w_data[g]),
      .o_valid   (w_valid[g+1]),
      .i_ready   (w_ready[g+1]),
      .o_data    (w_data[g+1])
    );
  end

  assign o_valid   = w_valid[N_STAGES];
  assign o_result  = w_data[N_STAGES][NB_DATA-1:0];
  assign o_illegal = w_data[N_STAGES][NB_DATA];
`ifdef ALU_FLAGS_EN
  assign o_flags   = w_data[N_STAGES][NB_PAYLOAD-1:NB_DATA+1];
`else
  assign o_flags   = 4'b0000;
`endif

endmodule
